// File: rtl/fifo_pop_trans_sequencer.sv
// Read-side sequencer for a transactional USB IN FIFO: pops one packet, streams it to TX,
// then commits or rolls back the read. Define FIFO_POP_SEQ_RETRY_COUNT_EN for retry stats.
`timescale 1ns/1ps
module fifo_pop_trans_sequencer #(
  parameter int unsigned DATA_WID    = 8,
  parameter int unsigned LEN_WID     = 11,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                txStart,
  input  logic [LEN_WID-1:0]  maxPacketSize,
  input  logic                ackReceived,
  input  logic                nakOrTimeout,
  input  logic                fifoDataAvailable,
  input  logic [DATA_WID-1:0] fifoDataOut,
  output logic                fifoPopData,
  output logic                fifoPopTransDone,
  output logic                fifoPopTransSuccess,
  output logic                txDataValid,
  input  logic                txReady,
  output logic [DATA_WID-1:0] txData,
  output logic                txLast,
  output logic                txZeroLen,
  output logic                busy,
`ifdef FIFO_POP_SEQ_RETRY_COUNT_EN
  output logic [3:0]          retryCount,
  output logic                retryExceeded,
`endif
  output logic [LEN_WID-1:0]  bytesSent
);

  typedef enum logic [3:0] {
    StRstRollback,
    StIdle,
    StLoad,
    StDecide,
    StPresent,
    StZlp,
    StWaitResult,
    StCommit,
    StRollback
  } seqState;

  seqState             stateQ, stateD;
  logic [LEN_WID-1:0]  cntQ;
  logic [LEN_WID-1:0]  maxQ;
  logic                lastQ;
  logic [DATA_WID-1:0] txDataQ;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stateQ  <= StRstRollback;
      cntQ    <= '0;
      maxQ    <= '0;
      lastQ   <= 1'b0;
      txDataQ <= '0;
    end else begin
      stateQ <= stateD;
      case (stateQ)
        StIdle: begin
          if (txStart) begin
            cntQ <= '0;
            maxQ <= maxPacketSize;
          end
        end
        StLoad: begin
          txDataQ <= fifoDataOut;
          cntQ    <= cntQ + LEN_WID'(1);
        end
        // Freeze the last-byte decision; later writer commits cannot change it.
        StDecide: lastQ <= (cntQ == maxQ) || !fifoDataAvailable;
        default: ;
      endcase
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StRstRollback: stateD = StIdle;
      StIdle: begin
        if (txStart) begin
          stateD = (fifoDataAvailable && (maxPacketSize != '0)) ? StLoad : StZlp;
        end
      end
      StLoad:    stateD = StDecide;
      StDecide:  stateD = StPresent;
      StPresent: begin
        if (txReady) stateD = lastQ ? StWaitResult : StLoad;
      end
      StZlp: begin
        if (txReady) stateD = StWaitResult;
      end
      StWaitResult: begin
        if (nakOrTimeout)     stateD = StRollback;
        else if (ackReceived) stateD = StCommit;
      end
      StCommit:   stateD = StIdle;
      StRollback: stateD = StIdle;
      default:    stateD = StRstRollback;
    endcase
  end

  // Reset is synchronous, so outputs are masked combinationally while RST is high.
  always_comb begin
    fifoPopData         = !RST && (stateQ == StLoad);
    fifoPopTransDone    = !RST && ((stateQ == StRstRollback) || (stateQ == StCommit) ||
                                   (stateQ == StRollback));
    fifoPopTransSuccess = !RST && (stateQ == StCommit);
    txDataValid         = !RST && ((stateQ == StPresent) || (stateQ == StZlp));
    txLast              = !RST && (((stateQ == StPresent) && lastQ) || (stateQ == StZlp));
    txZeroLen           = !RST && (stateQ == StZlp);
    txData              = RST ? '0 : txDataQ;
    bytesSent           = RST ? '0 : cntQ;
    busy                = RST || (stateQ != StIdle);
  end

`ifdef FIFO_POP_SEQ_RETRY_COUNT_EN
  logic [3:0] retryQ;

  always_ff @(posedge CLK) begin
    if (RST) begin
      retryQ <= '0;
    end else if (stateQ == StCommit) begin
      retryQ <= '0;
    end else if ((stateQ == StRollback) && (retryQ != 4'hF)) begin
      retryQ <= retryQ + 4'd1;
    end
  end

  always_comb begin
    retryCount    = RST ? 4'd0 : retryQ;
    retryExceeded = !RST && (32'(retryQ) >= MAX_RETRIES);
  end
`endif

endmodule

// File: doc/fifo_pop_trans_sequencer.md
Name: fifo_pop_trans_sequencer

Overview:
- Read-side controller for the transactional FIFO behind a USB IN endpoint.
- On request, pops one packet (up to maxPacketSize bytes) out of the FIFO and streams it to the packet TX path through a valid/ready handshake.
- Waits for the host handshake result, then commits the read transaction (ACK) or rolls it back (NAK/timeout) so the same bytes are resent on retry.
- Owns all of the FIFO's popData / popTransDone / popTransSuccess inputs.

Parameters:
- DATA_WID, 8: FIFO/TX data width.
- LEN_WID, 11: width of packet length and byte counters (max 2**LEN_WID-1 bytes).
- MAX_RETRIES, 3: rollback count at which retryExceeded asserts (optional feature only).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- txStart  in  1  request to send one packet; ignored while busy.
- maxPacketSize  in  LEN_WID  packet length limit, sampled when txStart is accepted.
- ackReceived  in  1  host ACK for the sent packet.
- nakOrTimeout  in  1  host NAK or response timeout.
- fifoDataAvailable  in  1  FIFO dataAvailable.
- fifoDataOut  in  DATA_WID  FIFO dataOut, valid in the same cycle as fifoDataAvailable.
- fifoPopData  out  1  FIFO popData.
- fifoPopTransDone  out  1  FIFO popTransDone.
- fifoPopTransSuccess  out  1  FIFO popTransSuccess.
- txDataValid  out  1  TX byte/ZLP valid.
- txReady  in  1  TX accepts the current item.
- txData  out  DATA_WID  registered TX byte.
- txLast  out  1  current item is the last of the packet.
- txZeroLen  out  1  current item is a zero-length packet marker (txData don't-care).
- busy  out  1  high in every state except IDLE.
- bytesSent  out  LEN_WID  bytes popped in the current or last packet.

Behaviour:
- States: RST_ROLLBACK, IDLE, LOAD, DECIDE, PRESENT, ZLP, WAIT_RESULT, COMMIT, ROLLBACK.

Reset:
- While RST=1: state=RST_ROLLBACK; all outputs 0; bytesSent=0; busy=1.
- First cycle after RST=0: RST_ROLLBACK drives fifoPopTransDone=1 and fifoPopTransSuccess=0 for one cycle, then goes to IDLE.
- This realigns the FIFO read pointer, which is not reset by RST.
- RST mid-packet therefore discards any uncommitted pops.

State transitions:
- IDLE, txStart=1:
  - Clear the byte counter and latch maxPacketSize.
  - Go to LOAD if fifoDataAvailable=1 and maxPacketSize!=0, else go to ZLP.
- LOAD (1 cycle):
  - fifoPopData=1; the handshake is guaranteed because availability was checked.
  - txData <= fifoDataOut; counter++ -> DECIDE.
- DECIDE (1 cycle):
  - lastReg <= (counter==latchedMax) || !fifoDataAvailable.
  - The next FIFO entry is visible this cycle. -> PRESENT.
- PRESENT:
  - txDataValid=1, txLast=lastReg.
  - txData and txLast stay stable until txReady=1.
  - On handshake: lastReg=1 -> WAIT_RESULT, else -> LOAD.
  - Throughput is 1 byte per 3 cycles minimum.
- ZLP:
  - txDataValid=1, txLast=1, txZeroLen=1, no pops.
  - On txReady -> WAIT_RESULT; counter stays 0.
- WAIT_RESULT:
  - nakOrTimeout=1 -> ROLLBACK.
  - Else ackReceived=1 -> COMMIT.
  - If both are high, NAK wins.
  - Result inputs in any other state are ignored.
- COMMIT (1 cycle): fifoPopTransDone=1, fifoPopTransSuccess=1 -> IDLE.
- ROLLBACK (1 cycle): fifoPopTransDone=1, fifoPopTransSuccess=0 -> IDLE.

Invariants:
- fifoPopData and fifoPopTransDone are never high in the same cycle.
- fifoPopTransSuccess is only ever high together with fifoPopTransDone.
- bytesSent = counter. It holds its value in IDLE and is cleared on txStart acceptance.
- The counter never exceeds the latched maximum and never wraps.
- Data committed by the FIFO writer during a packet may extend it; the last-byte decision is frozen in DECIDE.

Optional Feature:
- Macro: FIFO_POP_SEQ_RETRY_COUNT_EN.
- When defined:
  - Adds output retryCount (4 bits) and output retryExceeded (1 bit).
  - retryCount increments, saturating at 15, on each ROLLBACK entry (not RST_ROLLBACK).
  - retryCount clears on COMMIT and on RST.
  - retryExceeded = (retryCount >= MAX_RETRIES).
  - Advisory only; sequencing is unchanged.
- When undefined: the ports and the counter do not exist, and behaviour is otherwise identical.

Test Plan:
1. FIFO holds 5 committed bytes 0x01..0x05, maxPacketSize=8, txStart, txReady=1 -> TX sees 0x01..0x05 with txLast only on 0x05. ackReceived then gives one cycle of done=1/success=1, bytesSent=5, fifoDataAvailable=0.
2. 20 bytes 0x00..0x13, max=8, ACK each packet -> packet 1 is 0x00..0x07 (last on 0x07), packet 2 is 0x08..0x0F, packet 3 is 0x10..0x13 with last on 0x13.
3. 3 bytes 0xA0..0xA2, then nakOrTimeout -> done=1/success=0 pulse. Next txStart resends 0xA0..0xA2. A retry with ackReceived and nakOrTimeout high together also rolls back.
4. Empty FIFO, or maxPacketSize=0, then txStart -> one item with txZeroLen=1, txLast=1, no fifoPopData, bytesSent=0; ACK commits with the pointer unchanged.
5. txReady held low 10 cycles in PRESENT -> txData/txLast stable, exactly 1 fifoPopData per byte, txStart pulses ignored (busy=1).
6. RST asserted in PRESENT after 2 pops -> outputs 0 during reset, one rollback pulse after release, then a new txStart resends from the first byte. With FIFO_POP_SEQ_RETRY_COUNT_EN defined: 3 NAKs give retryCount=3 and retryExceeded=1; an ACK clears both.
